dh_modexp: RTL and testbench

Iterative modular exponentiation engine computing result = base^exponent mod p for the Diffie-Hellman datapath. It is the producer side of the key-computation path: it generates public values (g^x mod p) and shared keys (R^x mod p) entirely in the modular domain, so no 64-bit raw power is ever formed. Operands are loaded with a start pulse, and the result is returned with a one-cycle done strobe. Internally it runs a left-to-right square-and-multiply sequence over a bit-serial modular multiplier.

---
 rtl/dh_pkg.sv | 19 +
 rtl/dh_modmul.sv | 105 ++++++++++
 rtl/dh_modexp.sv | 209 ++++++++++++++++++++
 tb/tb_dh_modexp.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dh_pkg.sv
// dh_pkg: shared definitions for the Diffie-Hellman modular exponentiation slice.
//   DH_WIDTH      : default operand / modulus width in bits
//   dh_state_e    : exponentiation FSM state encoding
//   DH_MODMUL_LAT : cycles one modular multiply occupies an FSM state
//                   (one issue cycle plus one cycle per multiplier bit)
package dh_pkg;

    localparam int DH_WIDTH      = 32;
    localparam int DH_MODMUL_LAT = DH_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REDUCE = 3'd1,
        ST_SQR    = 3'd2,
        ST_MUL    = 3'd3,
        ST_FIN    = 3'd4
    } dh_state_e;

endpackage

// File: rtl/dh_modmul.sv
// dh_modmul: bit-serial modular multiplier, r = (a * b) mod p.
// Scans b MSB first, one bit per cycle, doubling and conditionally adding a,
// reducing after each step so the running value never leaves [0, p).
// Precondition: a < p.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   go       : one-cycle request; a, b, p are sampled in that cycle
//   a, b, p  : multiplicand, multiplier, modulus
//   rdy      : one-cycle pulse exactly WIDTH cycles after go; r valid then
//   r        : product mod p (held until the next go)
module dh_modmul
    import dh_pkg::*;
#(
    parameter int WIDTH = DH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             rdy,
    output logic [WIDTH-1:0] r
);

    localparam int JW = $clog2(WIDTH);

    // One double-and-add step. Inputs r_in, a_in < p_in keep every
    // intermediate below 2p, so WIDTH+1 bits never overflow.
    function automatic logic [WIDTH-1:0] mod_step(
        input logic [WIDTH-1:0] r_in,
        input logic [WIDTH-1:0] a_in,
        input logic [WIDTH-1:0] p_in,
        input logic             bit_in
    );
        logic [WIDTH:0] t;
        t = {r_in, 1'b0};
        if (t >= {1'b0, p_in}) t = t - {1'b0, p_in};
        else                   t = t;
        if (bit_in) t = t + {1'b0, a_in};
        else        t = t;
        if (t >= {1'b0, p_in}) t = t - {1'b0, p_in};
        else                   t = t;
        return t[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d, r_q, r_d;
    logic [JW-1:0]    j_q, j_d;
    logic             run_q, run_d, rdy_q, rdy_d;

    // Next-state: the MSB step runs in the go cycle directly on the ports,
    // the remaining WIDTH-1 steps run from the captured operands.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        p_d   = p_q;
        r_d   = r_q;
        j_d   = j_q;
        run_d = run_q;
        rdy_d = 1'b0;
        if (go) begin
            a_d   = a;
            b_d   = b;
            p_d   = p;
            r_d   = mod_step({WIDTH{1'b0}}, a, p, b[WIDTH-1]);
            j_d   = JW'(WIDTH - 2);
            run_d = 1'b1;
        end else if (run_q) begin
            r_d = mod_step(r_q, a_q, p_q, b_q[j_q]);
            if (j_q == {JW{1'b0}}) begin
                run_d = 1'b0;
                rdy_d = 1'b1;
            end else begin
                j_d = j_q - {{(JW-1){1'b0}}, 1'b1};
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= {WIDTH{1'b0}};
            b_q   <= {WIDTH{1'b0}};
            p_q   <= {WIDTH{1'b0}};
            r_q   <= {WIDTH{1'b0}};
            j_q   <= {JW{1'b0}};
            run_q <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            p_q   <= p_d;
            r_q   <= r_d;
            j_q   <= j_d;
            run_q <= run_d;
            rdy_q <= rdy_d;
        end
    end

    assign rdy = rdy_q;
    assign r   = r_q;

endmodule

// File: rtl/dh_modexp.sv
// dh_modexp: iterative modular exponentiation, result = base^exponent mod p,
// left-to-right square-and-multiply over the dh_modmul bit-serial multiplier.
// Build option: DH_MODEXP_CONST_TIME_EN -- when defined, a multiply is issued
// for every exponent bit (discarded for zero bits) so latency does not depend
// on the exponent.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : request pulse, only honoured in IDLE
//   base      : base value (any value, reduced internally)
//   exponent  : exponent
//   p         : modulus, p >= 2 (smaller values raise err)
//   busy      : high in every state except IDLE
//   done      : one-cycle completion pulse
//   result    : base^exponent mod p, held until the next accepted start
//   err       : set with done when p < 2, held until the next accepted start
module dh_modexp
    import dh_pkg::*;
#(
    parameter int WIDTH = DH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TWO = {{(WIDTH-2){1'b0}}, 2'b10};

`ifdef DH_MODEXP_CONST_TIME_EN
    localparam logic CONST_TIME = 1'b1;
`else
    localparam logic CONST_TIME = 1'b0;
`endif

    dh_state_e        state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d, exp_q, exp_d, p_q, p_d;
    logic [WIDTH-1:0] b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             issued_q, issued_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic             go_s, mm_rdy_s, exp_bit_s;
    logic [WIDTH-1:0] mm_a_s, mm_b_s, mm_r_s, mul_val_s;

    dh_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk (clk),
        .rst (rst),
        .go  (go_s),
        .a   (mm_a_s),
        .b   (mm_b_s),
        .p   (p_q),
        .rdy (mm_rdy_s),
        .r   (mm_r_s)
    );

    assign exp_bit_s = exp_q[idx_q];
    // In constant-time mode a MUL on a zero bit computes but keeps acc.
    assign mul_val_s = exp_bit_s ? mm_r_s : acc_q;

    // FSM next-state and datapath. Each multiply state issues go in its
    // first cycle (issued_q low) and leaves on the multiplier's rdy pulse.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        exp_d    = exp_q;
        p_d      = p_q;
        b_d      = b_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        issued_d = issued_q;
        result_d = result_q;
        err_d    = err_q;
        go_s     = 1'b0;
        mm_a_s   = acc_q;
        mm_b_s   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = base;
                    exp_d    = exponent;
                    p_d      = p;
                    idx_d    = IW'(WIDTH - 1);
                    issued_d = 1'b0;
                    acc_d    = {WIDTH{1'b0}};
                    b_d      = {WIDTH{1'b0}};
                    result_d = {WIDTH{1'b0}};
                    if (p < TWO) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_REDUCE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REDUCE: begin
                // 1 * base through the multiplier yields base mod p.
                mm_a_s   = ONE;
                mm_b_s   = base_q;
                go_s     = ~issued_q;
                issued_d = 1'b1;
                if (mm_rdy_s) begin
                    b_d      = mm_r_s;
                    acc_d    = ONE;
                    issued_d = 1'b0;
                    state_d  = ST_SQR;
                end else begin
                    state_d = ST_REDUCE;
                end
            end
            ST_SQR: begin
                mm_a_s   = acc_q;
                mm_b_s   = acc_q;
                go_s     = ~issued_q;
                issued_d = 1'b1;
                if (mm_rdy_s) begin
                    acc_d    = mm_r_s;
                    issued_d = 1'b0;
                    if (CONST_TIME || exp_bit_s) begin
                        state_d = ST_MUL;
                    end else if (idx_q == {IW{1'b0}}) begin
                        result_d = mm_r_s;
                        state_d  = ST_FIN;
                    end else begin
                        idx_d   = idx_q - {{(IW-1){1'b0}}, 1'b1};
                        state_d = ST_SQR;
                    end
                end else begin
                    state_d = ST_SQR;
                end
            end
            ST_MUL: begin
                mm_a_s   = acc_q;
                mm_b_s   = b_q;
                go_s     = ~issued_q;
                issued_d = 1'b1;
                if (mm_rdy_s) begin
                    acc_d    = mul_val_s;
                    issued_d = 1'b0;
                    if (idx_q == {IW{1'b0}}) begin
                        result_d = mul_val_s;
                        state_d  = ST_FIN;
                    end else begin
                        idx_d   = idx_q - {{(IW-1){1'b0}}, 1'b1};
                        state_d = ST_SQR;
                    end
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Registered strobes follow the state being entered.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            base_q   <= {WIDTH{1'b0}};
            exp_q    <= {WIDTH{1'b0}};
            p_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            idx_q    <= {IW{1'b0}};
            issued_q <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            p_q      <= p_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            issued_q <= issued_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dh_modexp.sv
// tb_dh_modexp: self-checking bench for dh_modexp (WIDTH=32). Results are
// compared with a right-to-left square-and-multiply model using 64-bit
// integer arithmetic; latency with a popcount-based formula.
module tb_dh_modexp;
    import dh_pkg::*;

    localparam int LIMIT = 3000;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base;
    logic [31:0] exponent;
    logic [31:0] p;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;

    int total_cnt = 0;
    int bad_cnt   = 0;

    dh_modexp #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .exponent (exponent),
        .p        (p),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] ref_pow(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
        longint unsigned r, x, ee, mm;
        mm = 64'(m);
        r  = 64'd1 % mm;
        x  = 64'(b) % mm;
        ee = 64'(e);
        while (ee != 64'd0) begin
            if (ee[0]) r = (r * x) % mm;
            x  = (x * x) % mm;
            ee = ee >> 1;
        end
        return r[31:0];
    endfunction

    function automatic int ref_lat(input logic [31:0] e, input logic [31:0] m);
        int k;
        if (m < 32'd2) return 1;
`ifdef DH_MODEXP_CONST_TIME_EN
        k = DH_WIDTH;
`else
        k = $countones(e);
`endif
        return 1 + DH_MODMUL_LAT * (1 + DH_WIDTH + k);
    endfunction

    // One transaction; optionally toggles inputs and start while busy.
    task automatic run_op(input logic [31:0] b_in, input logic [31:0] e_in,
                          input logic [31:0] p_in, input bit noisy);
        logic [31:0] want_r;
        logic        want_err;
        int          want_lat;
        int          n;
        want_err = (p_in < 32'd2);
        want_r   = want_err ? 32'd0 : ref_pow(b_in, e_in, p_in);
        want_lat = ref_lat(e_in, p_in);
        @(negedge clk);
        base = b_in; exponent = e_in; p = p_in; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < LIMIT) begin
            if (noisy) begin
                start    = 1'($urandom_range(0, 1));
                base     = $urandom;
                exponent = $urandom;
                p        = $urandom;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check_eq("done_seen", 64'(done), 64'd1);
        check_eq("latency", 64'(n), 64'(want_lat));
        check_eq("result", 64'(result), 64'(want_r));
        check_eq("err", 64'(err), 64'(want_err));
        check_eq("busy_at_done", 64'(busy), 64'd1);
        @(negedge clk);
        check_eq("done_one_cycle", 64'(done), 64'd0);
        check_eq("busy_after_done", 64'(busy), 64'd0);
        check_eq("result_held", 64'(result), 64'(want_r));
        check_eq("err_held", 64'(err), 64'(want_err));
    endtask

    initial begin
        bit          seen;
        logic [31:0] rb, re, rp;
        rst = 1'b1; start = 1'b0; base = 32'd0; exponent = 32'd0; p = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(32'd5, 32'd3, 32'd17, 1'b0);
        run_op(32'd22, 32'd3, 32'd17, 1'b0);
        run_op(32'd3, 32'd13, 32'd7, 1'b0);
        run_op(32'd9, 32'd0, 32'd11, 1'b0);
        run_op(32'd7, 32'd5, 32'd1, 1'b0);
        run_op(32'd7, 32'd5, 32'd0, 1'b0);
        run_op(32'd4, 32'd6, 32'd13, 1'b0);
        run_op(32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);

        // Reset in the middle of a computation
        @(negedge clk);
        base = 32'd5; exponent = 32'h0000_FFFF; p = 32'd17; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_done", 64'(done), 64'd0);
        check_eq("midrst_result", 64'(result), 64'd0);
        check_eq("midrst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (2300) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_eq("no_done_after_rst", 64'(seen), 64'd0);
        run_op(32'd5, 32'd3, 32'd17, 1'b0);

        // Randomized cases
        for (int i = 0; i < 8; i++) begin
            rb = $urandom;
            re = $urandom >> $urandom_range(0, 31);
            if (i < 4) rp = $urandom_range(2, 1000);
            else       rp = $urandom | 32'h8000_0000;
            run_op(rb, re, rp, (i % 2) == 1);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
